// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the 7-segment scan driver: segment patterns,
// scan FSM states and a small elaboration-time helper.
package seg7_scan_driver_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_state_t;

  // Segment patterns, bit0=a .. bit6=g, active-high (polarity applied later)
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Hex nibble to active-high a..g segment pattern; purely combinational.
module hex_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the 16 hex glyphs
  always_comb begin
    seg = SEG_0;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: per-digit blank/on phases on clken
// ticks, once-per-frame value snapshot, leading-zero blanking, registered
// polarity-corrected outputs.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIGIT_TICKS  = 4,
  parameter int unsigned BLANK_TICKS  = 1,
  parameter int unsigned COMMON_ANODE = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      clken,
  input  logic                      enable,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic                      lzb,
  output logic [6:0]                seg,
  output logic                      seg_dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_start
);

  localparam int unsigned CW  = $clog2(max_u(DIGIT_TICKS, BLANK_TICKS) + 1);
  localparam int unsigned DW  = $clog2(NUM_DIGITS);
  localparam logic        INV = (COMMON_ANODE != 0);

  scan_state_t             state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DW-1:0]           dig_q, dig_d;
  logic                    restart_q, restart_d;
  logic                    frame_d;
  logic [4*NUM_DIGITS-1:0] shadow_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q;

  logic [3:0]              cur_nibble;
  logic [6:0]              seg_hex;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic [6:0]              seg_act;
  logic                    dp_act;
  logic [NUM_DIGITS-1:0]   an_act;

  // restart_q marks "frame start owed": set by reset or enable=0, it turns
  // the first enabled edge into a frame start without advancing the scan.
  // Scan FSM, tick counter and digit index registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_BLANK;
      cnt_q     <= '0;
      dig_q     <= '0;
      restart_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      restart_q <= restart_d;
    end
  end

  // Next-state: enable override, restart frame start, then tick-driven scan
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dig_d     = dig_q;
    restart_d = restart_q;
    frame_d   = 1'b0;
    if (!enable) begin
      state_d   = ST_BLANK;
      cnt_d     = '0;
      dig_d     = '0;
      restart_d = 1'b1;
    end else if (restart_q) begin
      state_d   = ST_BLANK;
      cnt_d     = '0;
      dig_d     = '0;
      restart_d = 1'b0;
      frame_d   = 1'b1;
    end else if (clken) begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == CW'(BLANK_TICKS - 1)) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_ON: begin
          if (cnt_q == CW'(DIGIT_TICKS - 1)) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (dig_q == DW'(NUM_DIGITS - 1)) begin
              dig_d   = '0;
              frame_d = 1'b1;
            end else begin
              dig_d = dig_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_BLANK;
      endcase
    end
  end

  // Frame snapshot of value and decimal points, plus the frame_start pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_d;
      if (frame_d) begin
        shadow_q    <= value;
        shadow_dp_q <= dp;
      end
    end
  end

  hex_to_seg7 u_hex (
    .nibble (cur_nibble),
    .seg    (seg_hex)
  );

  // Active-high decode of the current FSM state with leading-zero masking
  always_comb begin
    cur_nibble = shadow_q[4*int'(dig_q) +: 4];
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      lead_zero[i] = ((shadow_q >> (4*i)) == '0);
    end
    an_act  = '0;
    seg_act = '0;
    dp_act  = 1'b0;
    if (enable && state_q == ST_ON) begin
      an_act[dig_q] = 1'b1;
      seg_act       = (lzb && dig_q != '0 && lead_zero[dig_q]) ? 7'h00 : seg_hex;
      dp_act        = shadow_dp_q[dig_q];
    end
  end

  // Output registers with display polarity applied
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seg    <= {7{INV}};
      seg_dp <= INV;
      an     <= {NUM_DIGITS{INV}};
    end else begin
      seg    <= seg_act ^ {7{INV}};
      seg_dp <= dp_act ^ INV;
      an     <= an_act ^ {NUM_DIGITS{INV}};
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: tick-position reference model
// compared every cycle, plus literal frame expectations.
module tb_seg7_scan_driver;

  logic        clock = 1'b0;
  logic        reset_n, clken, enable, lzb;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [6:0]  seg;
  logic        seg_dp, frame_start;
  logic [3:0]  an;

  logic        rst2_n;
  logic [6:0]  seg2;
  logic        seg_dp2, fs2;
  logic [1:0]  an2;

  int n_checks = 0;
  int n_pass   = 0;
  int clk_mode = 0;
  int cyc      = 0;

  logic [3:0] an_s  [1:80];
  logic [6:0] seg_s [1:80];
  logic       dp_s  [1:80];
  logic       fs_s  [1:80];

  always #5 clock = ~clock;

  seg7_scan_driver u_dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .clken       (clken),
    .enable      (enable),
    .value       (value),
    .dp          (dp),
    .lzb         (lzb),
    .seg         (seg),
    .seg_dp      (seg_dp),
    .an          (an),
    .frame_start (frame_start)
  );

  seg7_scan_driver #(.NUM_DIGITS(2), .COMMON_ANODE(0)) u_dut2 (
    .clock       (clock),
    .reset_n     (rst2_n),
    .clken       (1'b1),
    .enable      (1'b1),
    .value       (8'h5A),
    .dp          (2'b01),
    .lzb         (1'b0),
    .seg         (seg2),
    .seg_dp      (seg_dp2),
    .an          (an2),
    .frame_start (fs2)
  );

  task automatic chk(input bit ok, input string name, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic logic [6:0] hexseg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Reference model: scan position m_p counts clken ticks within a 20-tick
  // frame (4 digits x (1 blank + 4 lit)); outputs show the previous position.
  logic        m_pend;
  int          m_p;
  logic [15:0] m_sh;
  logic [3:0]  m_sdp;

  always @(posedge clock) begin : model
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fs;
    int         slot, off;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
    if (!reset_n) begin
      m_pend = 1'b1; m_p = 0; m_sh = '0; m_sdp = '0;
    end else begin
      slot = m_p / 5;
      off  = m_p % 5;
      if (enable && !m_pend && off >= 1) begin
        e_an  = ~(4'b0001 << slot);
        e_seg = (lzb && slot > 0 && (m_sh >> (4*slot)) == 0) ? 7'h7F
                                                             : ~hexseg(m_sh[4*slot +: 4]);
        e_dp  = ~m_sdp[slot];
      end
      if (!enable) begin
        m_pend = 1'b1;
      end else if (m_pend) begin
        m_pend = 1'b0; m_p = 0; m_sh = value; m_sdp = dp; e_fs = 1'b1;
      end else if (clken) begin
        m_p = (m_p + 1) % 20;
        if (m_p == 0) begin
          m_sh = value; m_sdp = dp; e_fs = 1'b1;
        end
      end
    end
    #1;
    chk(an == e_an && seg == e_seg && seg_dp == e_dp && frame_start == e_fs, "model",
        $sformatf("t=%0t an=%h seg=%h dp=%b fs=%b, required an=%h seg=%h dp=%b fs=%b",
                  $time, an, seg, seg_dp, frame_start, e_an, e_seg, e_dp, e_fs));
  end

  // Slow tick generator: every 4th cycle, random, or tied high
  initial begin
    clken = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      case (clk_mode)
        0:       clken = (cyc % 4 == 0);
        1:       clken = 1'($urandom_range(0, 1));
        default: clken = 1'b1;
      endcase
    end
  end

  task automatic wait_frame();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      if (frame_start) begin
        ok = 1;
        break;
      end
    end
    chk(ok, "frame_wait", $sformatf("no frame_start within 200 cycles, required one"));
  endtask

  task automatic capture(input int chg_at, input logic [15:0] nv);
    for (int j = 1; j <= 80; j++) begin
      @(posedge clock); #1;
      an_s[j] = an; seg_s[j] = seg; dp_s[j] = seg_dp; fs_s[j] = frame_start;
      if (j == chg_at) value = nv;
    end
  endtask

  // Expected frame with clken every 4th cycle: 4 dark clocks, then 16 lit, per digit
  task automatic check_frame(input string name, input logic [6:0] es [4], input logic [3:0] edp);
    int bad = 0;
    logic [3:0] xa; logic [6:0] xs; logic xd, xf;
    string det = "";
    for (int j = 1; j <= 80; j++) begin
      int slot = (j - 1) / 20;
      int r    = (j - 1) % 20;
      if (r < 4) begin
        xa = 4'hF; xs = 7'h7F; xd = 1'b1;
      end else begin
        xa = ~(4'b0001 << slot); xs = es[slot]; xd = edp[slot];
      end
      xf = (j == 80);
      if (bad == 0 && (an_s[j] != xa || seg_s[j] != xs || dp_s[j] != xd || fs_s[j] != xf)) begin
        bad = j;
        det = $sformatf("sample %0d an=%h seg=%h dp=%b fs=%b, required an=%h seg=%h dp=%b fs=%b",
                        j, an_s[j], seg_s[j], dp_s[j], fs_s[j], xa, xs, xd, xf);
      end
    end
    chk(bad == 0, name, det);
  endtask

  initial begin
    logic [6:0] es [4];
    bit found;
    reset_n = 1'b0; rst2_n = 1'b0; enable = 1'b1; lzb = 1'b0;
    value = 16'h12AF; dp = 4'h0;

    repeat (2) @(posedge clock);
    #1;
    chk(an == 4'hF && seg == 7'h7F && seg_dp && !frame_start, "reset_main",
        $sformatf("an=%h seg=%h dp=%b fs=%b, required F 7f 1 0", an, seg, seg_dp, frame_start));
    chk(an2 == 2'b00 && seg2 == 7'h00 && !seg_dp2 && !fs2, "reset_ca0",
        $sformatf("an=%h seg=%h dp=%b fs=%b, required 0 00 0 0", an2, seg2, seg_dp2, fs2));

    // Active-high 2-digit instance, clken tied high: period 10 clocks
    @(negedge clock); rst2_n = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      logic [1:0] xa; logic [6:0] xs; logic xd, xf; int q;
      @(posedge clock); #1;
      q  = (k >= 3) ? (k - 3) % 10 : -1;
      xa = 2'b00; xs = 7'h00; xd = 1'b0;
      if (q >= 0 && q <= 3) begin xa = 2'b01; xs = 7'h77; xd = 1'b1; end
      else if (q >= 5 && q <= 8) begin xa = 2'b10; xs = 7'h6D; xd = 1'b0; end
      xf = (k % 10 == 1);
      chk(an2 == xa && seg2 == xs && seg_dp2 == xd && fs2 == xf, "ca0_scan",
          $sformatf("k=%0d an=%b seg=%h dp=%b fs=%b, required an=%b seg=%h dp=%b fs=%b",
                    k, an2, seg2, seg_dp2, fs2, xa, xs, xd, xf));
    end

    // Main instance: full frame of 12AF
    @(negedge clock); reset_n = 1'b1;
    wait_frame();
    wait_frame();
    capture(0, 16'h0);
    es = '{7'h0E, 7'h08, 7'h24, 7'h79};
    check_frame("frame_12AF", es, 4'hF);

    // Mid-frame value change must not tear the current frame
    wait_frame();
    capture(50, 16'h3456);
    check_frame("no_tear_12AF", es, 4'hF);
    wait_frame();
    capture(0, 16'h0);
    es = '{7'h02, 7'h12, 7'h19, 7'h30};
    check_frame("frame_3456", es, 4'hF);

    // Leading-zero blanking
    lzb = 1'b1; value = 16'h0050; dp = 4'b1000;
    wait_frame();
    capture(0, 16'h0);
    es = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    check_frame("lzb_0050", es, 4'b0111);
    value = 16'h0000; dp = 4'b0000;
    wait_frame();
    capture(0, 16'h0);
    es = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    check_frame("lzb_0000", es, 4'hF);

    // Enable drop during digit 1 lit
    lzb = 1'b0; value = 16'h12AF;
    wait_frame();
    repeat (30) @(posedge clock);
    #1;
    chk(an == 4'hD, "pre_disable", $sformatf("an=%h, required d", an));
    enable = 1'b0;
    @(posedge clock); #1;
    chk(an == 4'hF && seg == 7'h7F && seg_dp && !frame_start, "enable_off",
        $sformatf("an=%h seg=%h dp=%b fs=%b, required F 7f 1 0", an, seg, seg_dp, frame_start));
    repeat (4) @(posedge clock);
    #1;
    enable = 1'b1;
    @(posedge clock); #1;
    chk(frame_start == 1'b1, "restart_fs", $sformatf("fs=%b, required 1", frame_start));
    found = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (an == 4'hE) begin found = 1; break; end
    end
    chk(found, "restart_digit0", $sformatf("an=%h after 8 cycles, required e seen", an));

    // Asynchronous reset between edges while a digit is lit
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (an != 4'hF) begin found = 1; break; end
    end
    chk(found, "lit_before_reset", $sformatf("an=%h, required a lit digit", an));
    #3;
    reset_n = 1'b0;
    #1;
    chk(an == 4'hF && seg == 7'h7F && seg_dp && !frame_start, "async_reset",
        $sformatf("an=%h seg=%h dp=%b fs=%b, required F 7f 1 0", an, seg, seg_dp, frame_start));
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk(frame_start == 1'b1, "reset_release_fs", $sformatf("fs=%b, required 1", frame_start));

    // Randomized traffic, random then continuous clken
    clk_mode = 1;
    for (int c = 0; c < 3400; c++) begin
      if (c == 3000) clk_mode = 2;
      @(negedge clock);
      if ($urandom_range(0, 15) == 0) begin
        value = ($urandom_range(0, 2) == 0) ? (16'($urandom) & 16'h00F0) : 16'($urandom);
        dp    = 4'($urandom);
        lzb   = 1'($urandom_range(0, 1));
      end
      enable = ($urandom_range(0, 63) != 0);
    end

    @(posedge clock); #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
